mem_burst_rd_master: RTL and testbench

Channel-side read initiator for one chN_rd_burst port of the DDR2 multi-channel controller. It takes a single transfer command (base word address plus total word count) and splits it into bursts of at most BURST_LEN words. For each burst it drives the rd_burst req/len/addr handshake and collects the returned beats in an internal FIFO. Data leaves the FIFO on a valid/ready stream toward video or line-buffer logic.

---
 rtl/mem_burst_rd_master.sv | 146 ++++++++++++++
 tb/tb_mem_burst_rd_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_rd_master.sv
// Burst read initiator: splits a transfer into bursts of up to BURST_LEN words and buffers beats in a FWFT FIFO.
// Optional beat-count protocol checker enabled by defining MEM_BURST_RD_MASTER_CHK_EN.
module mem_burst_rd_master #(
  parameter int MEM_DATA_BITS = 32,
  parameter int BURST_LEN     = 128,
  parameter int FIFO_DEPTH    = 512,
  parameter int FIFO_AW       = 9
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [23:0]              start_addr,
  input  logic [23:0]              total_len,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_burst_req,
  output logic [9:0]               rd_burst_len,
  output logic [23:0]              rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     rd_burst_finish,
  output logic                     out_valid,
  output logic [MEM_DATA_BITS-1:0] out_data,
  input  logic                     out_ready,
  output logic [FIFO_AW:0]         fifo_level,
  output logic                     err
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_SPACE = 3'd1;
  localparam logic [2:0] S_REQ        = 3'd2;
  localparam logic [2:0] S_NEXT       = 3'd3;
  localparam logic [2:0] S_FINISH     = 3'd4;

  localparam logic [23:0]      BURST_LEN_W = 24'(BURST_LEN);
  localparam logic [FIFO_AW:0] DEPTH_W     = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [2:0]  state;
  logic [23:0] cur_addr;
  logic [23:0] remain;
  logic [9:0]  blen;
  logic [FIFO_AW:0] space;
  logic        space_ok;
  logic        push, pop;

  assign blen     = (remain < BURST_LEN_W) ? remain[9:0] : BURST_LEN_W[9:0];
  assign space    = DEPTH_W - fifo_level;
  assign space_ok = 24'(space) >= 24'(blen);

  assign busy = (state != S_IDLE) && (state != S_FINISH);
  assign done = (state == S_FINISH);

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      remain        <= '0;
      rd_burst_req  <= 1'b0;
      rd_burst_len  <= '0;
      rd_burst_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cur_addr <= start_addr;
          remain   <= total_len;
          state    <= (total_len == 24'd0) ? S_FINISH : S_WAIT_SPACE;
        end
        // Reserve the whole burst in the FIFO before asking, so beats never overflow.
        S_WAIT_SPACE: if (space_ok) begin
          rd_burst_len  <= blen;
          rd_burst_addr <= cur_addr;
          rd_burst_req  <= 1'b1;
          state         <= S_REQ;
        end
        S_REQ: if (rd_burst_finish) begin
          rd_burst_req <= 1'b0;
          state        <= S_NEXT;
        end
        S_NEXT: begin
          cur_addr <= cur_addr + 24'(rd_burst_len);
          remain   <= remain - 24'(rd_burst_len);
          state    <= (remain == 24'(rd_burst_len)) ? S_FINISH : S_WAIT_SPACE;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_BURST_RD_MASTER_CHK_EN
  logic [9:0] beat_cnt;
  logic       beat_in_req, beat_excess;

  assign beat_in_req = rd_burst_data_valid && (state == S_REQ);
  assign beat_excess = beat_in_req && (beat_cnt == rd_burst_len);
  assign push        = beat_in_req && !beat_excess;

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state != S_REQ)
        beat_cnt <= '0;
      else if (push)
        beat_cnt <= beat_cnt + 10'd1;
      if ((rd_burst_data_valid && state != S_REQ) || beat_excess)
        err <= 1'b1;
      // A beat landing together with finish still counts toward this burst.
      if (state == S_REQ && rd_burst_finish && (beat_cnt + 10'(push)) != rd_burst_len)
        err <= 1'b1;
    end
  end
`else
  assign push = rd_burst_data_valid && (state == S_REQ);
  assign err  = 1'b0;
`endif

  logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr, rd_ptr;

  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (push) mem[wr_ptr] <= rd_burst_data;
  end

endmodule

// File: tb/tb_mem_burst_rd_master.sv
// Directed bench for mem_burst_rd_master: arbiter responder, output monitor, per-scenario tasks.
module tb_mem_burst_rd_master;
  logic        mem_clk, rst_n, start;
  logic [23:0] start_addr, total_len;
  logic        busy, done, rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [23:0] rd_burst_addr;
  logic        rd_burst_data_valid, rd_burst_finish;
  logic [31:0] rd_burst_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [9:0]  fifo_level;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  int extra_beats = 0;
  logic [9:0]  blen_q[$];
  logic [23:0] baddr_q[$];
  logic [31:0] got_q[$];

  mem_burst_rd_master dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .total_len(total_len), .busy(busy), .done(done), .rd_burst_req(rd_burst_req),
    .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .fifo_level(fifo_level), .err(err)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {8'h5A, a};
  endfunction

  // Arbiter responder: 2-cycle latency, len (+extra) beats, then a finish pulse.
  initial begin : arb
    int n;
    logic [23:0] a;
    bit aborted;
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
    rd_burst_data       = '0;
    forever begin
      @(negedge mem_clk); #1;
      if (rd_burst_req && rst_n) begin
        blen_q.push_back(rd_burst_len);
        baddr_q.push_back(rd_burst_addr);
        n = int'(rd_burst_len) + extra_beats;
        a = rd_burst_addr;
        aborted = 1'b0;
        repeat (2) @(negedge mem_clk);
        for (int i = 0; i < n && !aborted; i++) begin
          rd_burst_data_valid = 1'b1;
          rd_burst_data       = exp_word(a + 24'(i));
          @(negedge mem_clk); #1;
          if (!rst_n) aborted = 1'b1;
        end
        rd_burst_data_valid = 1'b0;
        if (!aborted) begin
          rd_burst_finish = 1'b1;
          @(negedge mem_clk); #1;
          rd_burst_finish = 1'b0;
        end
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge mem_clk); #1;
      if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic clear_logs();
    blen_q.delete(); baddr_q.delete(); got_q.delete();
  endtask

  task automatic do_start(input logic [23:0] a, input logic [23:0] l);
    @(negedge mem_clk); start = 1'b1; start_addr = a; total_len = l;
    @(negedge mem_clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output int req_fall, output bit ok);
    bit prev;
    prev = rd_burst_req; ok = 1'b0; cyc = -1; req_fall = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge mem_clk);
      if (prev && !rd_burst_req) req_fall = c;
      prev = rd_burst_req;
      if (done) begin ok = 1'b1; cyc = c; break; end
    end
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge mem_clk);
      if (fifo_level == 10'd0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge mem_clk);
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge mem_clk);
      if (rd_burst_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge mem_clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_chk++; if (rd_burst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", rd_burst_req); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_chk++; if (rd_burst_len !== 10'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", rd_burst_len); end
    n_chk++; if (rd_burst_addr !== 24'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", rd_burst_addr); end
    n_chk++; if (fifo_level !== 10'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    rst_n = 1'b1;
    @(negedge mem_clk);
  endtask

  task automatic test_single();
    int cyc, rf; bit ok;
    clear_logs(); out_ready = 1'b1;
    do_start(24'h000100, 24'd16);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hi got %b want 1", busy); end
    wait_done(400, cyc, rf, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_done_timeout got 0 want 1"); end
    n_chk++; if (cyc - rf !== 1) begin n_fail++; $display("FAIL single_done_latency got %0d want 1", cyc - rf); end
    @(negedge mem_clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width got %b want 0", done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_lo got %b want 0", busy); end
    wait_drain(100, ok);
    n_chk++; if (blen_q.size() !== 1) begin n_fail++; $display("FAIL single_nbursts got %0d want 1", blen_q.size()); end
    if (blen_q.size() > 0) begin
      n_chk++; if (blen_q[0] !== 10'd16) begin n_fail++; $display("FAIL single_len got %0d want 16", blen_q[0]); end
      n_chk++; if (baddr_q[0] !== 24'h000100) begin n_fail++; $display("FAIL single_addr got %h want 000100", baddr_q[0]); end
    end
    n_chk++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL single_nwords got %0d want 16", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 16; k++) begin
      n_chk++; if (got_q[k] !== exp_word(24'h000100 + 24'(k))) begin n_fail++; $display("FAIL single_word[%0d] got %h want %h", k, got_q[k], exp_word(24'h000100 + 24'(k))); end
    end
  endtask

  task automatic test_multi();
    int cyc, rf; bit ok;
    logic [9:0]  el [3];
    logic [23:0] ea [3];
    el[0] = 10'd128; el[1] = 10'd128; el[2] = 10'd44;
    ea[0] = 24'h001000; ea[1] = 24'h001080; ea[2] = 24'h001100;
    clear_logs(); out_ready = 1'b1;
    do_start(24'h001000, 24'd300);
    wait_done(2000, cyc, rf, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL multi_done_timeout got 0 want 1"); end
    wait_drain(200, ok);
    n_chk++; if (blen_q.size() !== 3) begin n_fail++; $display("FAIL multi_nbursts got %0d want 3", blen_q.size()); end
    for (int b = 0; b < 3 && b < blen_q.size(); b++) begin
      n_chk++; if (blen_q[b] !== el[b]) begin n_fail++; $display("FAIL multi_len[%0d] got %0d want %0d", b, blen_q[b], el[b]); end
      n_chk++; if (baddr_q[b] !== ea[b]) begin n_fail++; $display("FAIL multi_addr[%0d] got %h want %h", b, baddr_q[b], ea[b]); end
    end
    n_chk++; if (got_q.size() !== 300) begin n_fail++; $display("FAIL multi_nwords got %0d want 300", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 300; k++) begin
      n_chk++; if (got_q[k] !== exp_word(24'h001000 + 24'(k))) begin n_fail++; $display("FAIL multi_word[%0d] got %h want %h", k, got_q[k], exp_word(24'h001000 + 24'(k))); end
    end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL multi_err got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    int cyc, rf; bit ok;
    clear_logs(); out_ready = 1'b0;
    do_start(24'h002000, 24'd1024);
    repeat (800) @(negedge mem_clk);
    n_chk++; if (fifo_level !== 10'd512) begin n_fail++; $display("FAIL bp_level got %0d want 512", fifo_level); end
    n_chk++; if (blen_q.size() !== 4) begin n_fail++; $display("FAIL bp_nbursts got %0d want 4", blen_q.size()); end
    n_chk++; if (rd_burst_req !== 1'b0) begin n_fail++; $display("FAIL bp_req got %b want 0", rd_burst_req); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy got %b want 1", busy); end
    out_ready = 1'b1;
    wait_done(3000, cyc, rf, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout got 0 want 1"); end
    wait_drain(700, ok);
    n_chk++; if (blen_q.size() !== 8) begin n_fail++; $display("FAIL bp_nbursts_total got %0d want 8", blen_q.size()); end
    n_chk++; if (got_q.size() !== 1024) begin n_fail++; $display("FAIL bp_nwords got %0d want 1024", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 1024; k++) begin
      n_chk++; if (got_q[k] !== exp_word(24'h002000 + 24'(k))) begin n_fail++; $display("FAIL bp_word[%0d] got %h want %h", k, got_q[k], exp_word(24'h002000 + 24'(k))); end
    end
  endtask

  task automatic test_zero_and_ignored();
    int cyc, rf; bit ok;
    clear_logs(); out_ready = 1'b1;
    do_start(24'h000050, 24'd0);
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    n_chk++; if (rd_burst_req !== 1'b0) begin n_fail++; $display("FAIL zero_req got %b want 0", rd_burst_req); end
    @(negedge mem_clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width got %b want 0", done); end
    repeat (5) @(negedge mem_clk);
    n_chk++; if (blen_q.size() !== 0) begin n_fail++; $display("FAIL zero_nbursts got %0d want 0", blen_q.size()); end
    do_start(24'h000300, 24'd16);
    wait_req(20, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL ign_req_timeout got 0 want 1"); end
    do_start(24'h000777, 24'd5);
    repeat (2) @(negedge mem_clk);
    n_chk++; if (rd_burst_len !== 10'd16) begin n_fail++; $display("FAIL ign_len got %0d want 16", rd_burst_len); end
    n_chk++; if (rd_burst_addr !== 24'h000300) begin n_fail++; $display("FAIL ign_addr got %h want 000300", rd_burst_addr); end
    wait_done(400, cyc, rf, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL ign_done_timeout got 0 want 1"); end
    repeat (10) @(negedge mem_clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_after got %b want 0", busy); end
    n_chk++; if (blen_q.size() !== 1) begin n_fail++; $display("FAIL ign_nbursts got %0d want 1", blen_q.size()); end
    n_chk++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL ign_nwords got %0d want 16", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs(); out_ready = 1'b0;
    do_start(24'h000400, 24'd64);
    wait_req(20, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_req_timeout got 0 want 1"); end
    repeat (6) @(negedge mem_clk);
    n_chk++; if (fifo_level === 10'd0) begin n_fail++; $display("FAIL rmid_level_pre got 0 want nonzero"); end
    rst_n = 1'b0;
    @(negedge mem_clk);
    n_chk++; if (rd_burst_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req got %b want 0", rd_burst_req); end
    n_chk++; if (fifo_level !== 10'd0) begin n_fail++; $display("FAIL rmid_level got %0d want 0", fifo_level); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    @(negedge mem_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge mem_clk);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err got %b want 0", err); end
  endtask

`ifdef MEM_BURST_RD_MASTER_CHK_EN
  task automatic test_chk();
    int cyc, rf; bit ok;
    clear_logs(); out_ready = 1'b0; extra_beats = 1;
    do_start(24'h000500, 24'd16);
    wait_done(400, cyc, rf, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL chk_done_timeout got 0 want 1"); end
    repeat (5) @(negedge mem_clk);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL chk_err got %b want 1", err); end
    n_chk++; if (fifo_level !== 10'd16) begin n_fail++; $display("FAIL chk_level got %0d want 16", fifo_level); end
    extra_beats = 0; out_ready = 1'b1;
    wait_drain(100, ok);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL chk_err_sticky got %b want 1", err); end
    n_chk++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL chk_nwords got %0d want 16", got_q.size()); end
    @(negedge mem_clk); rst_n = 1'b0;
    @(negedge mem_clk); rst_n = 1'b1;
    @(negedge mem_clk);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL chk_err_cleared got %b want 0", err); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; total_len = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_zero_and_ignored();
    test_reset_mid();
`ifdef MEM_BURST_RD_MASTER_CHK_EN
    test_chk();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
